// File: rtl/sram_stream_reader_pkg.sv
// ==========================================================================
// sram_stream_reader_pkg : shared SRAM geometry defaults and FSM encodings
// Rev 1.0
// ==========================================================================
`default_nettype none

package sram_stream_reader_pkg;

  // Defaults shared with the SRAM macro wrapper and the capture-side writer
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 15;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage : sram_stream_reader_pkg

`default_nettype wire

// File: rtl/sram_stream_reader.sv
// ==========================================================================
// sram_stream_reader : walks SRAM from a base address, streams words out
// Rev 1.0
// ==========================================================================
`default_nettype none

module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_done;

  logic w_slot_free;
  logic w_load;
  logic w_drained;

  // The output register can take a new word when empty or being consumed this cycle
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_load      = (r_state == ST_RUN) && (r_rem != '0) && w_slot_free;
  assign w_drained   = (r_state == ST_RUN) && (r_rem == '0) && w_slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr  <= start_addr;
            r_rem   <= length;
            r_busy  <= 1'b1;
            r_state <= (length == '0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            r_out_data  <= read_data;
            r_out_valid <= 1'b1;
            // Natural overflow of the address register wraps top-of-RAM to 0
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_rem       <= r_rem - (ADDR_WIDTH + 1)'(1);
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_drained) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_addr = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : sram_stream_reader

`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
// ==========================================================================
// tb_sram_stream_reader : directed bench with a behavioural async-read SRAM
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_sram_stream_reader;

  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign read_data = mem[read_addr];

  sram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .read_addr (read_addr),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns just after the edge that accepted it
  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    tick();
    start = 1'b0;
  endtask

  // Full-throughput stream check; optionally pulses a competing start after word 'inject'
  task automatic expect_stream(input string tag, input int n, input logic [DW-1:0] first,
                               input int inject);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_valid0"}, {31'd0, out_valid}, 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_word"}, {15'd0, out_valid, out_data}, {15'd0, 1'b1, first + DW'(i)});
      if (i == inject) begin
        start      = 1'b1;
        start_addr = 15'h0500;
        length     = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_end_busy"},  {31'd0, busy},      32'd1);
    chk({tag, "_end_done0"}, {31'd0, done},      32'd0);
    tick();
    chk({tag, "_done"},      {31'd0, done},      32'd1);
    chk({tag, "_busy_low"},  {31'd0, busy},      32'd0);
    tick();
    chk({tag, "_done_gone"}, {31'd0, done},      32'd0);
  endtask

  initial begin
    logic [31:0]   pat;
    logic [DW-1:0] held;
    logic          stall;
    int            k;
    bit            seen_done;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hDEAD;

    // Reset state
    tick();
    tick();
    chk("rst_outs", {7'd0, read_addr, out_data, out_valid, busy, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outs", {7'd0, read_addr, out_data, out_valid, busy, done}, 32'd0);

    // 1: 256 sequential words at full rate
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    out_ready = 1'b1;
    do_start(15'h0000, 16'd256);
    expect_stream("seq256", 256, 16'h0000, -1);

    // 2: wrap from top of RAM back to 0
    mem[15'h7FFE] = 16'h00A0;
    mem[15'h7FFF] = 16'h00A1;
    mem[15'h0000] = 16'h00A2;
    mem[15'h0001] = 16'h00A3;
    do_start(15'h7FFE, 16'd4);
    expect_stream("wrap", 4, 16'h00A0, -1);

    // 3: backpressure with a fixed irregular ready pattern
    for (int i = 0; i < 8; i++) mem[15'h0100 + AW'(i)] = 16'h5000 + DW'(i);
    pat = 32'b1001_1010_0101_1100_0011_0110_1001_1001;
    do_start(15'h0100, 16'd8);
    k = 0;
    stall = 1'b0;
    held = '0;
    seen_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid) chk("bp_word", {16'd0, out_data}, {16'd0, 16'h5000 + DW'(k)});
      if (stall) chk("bp_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, held});
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      out_ready = pat[c % 32];
      stall = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) k++;
      tick();
    end
    out_ready = 1'b1;
    chk("bp_count", k, 32'd8);
    chk("bp_done_seen", {31'd0, seen_done}, 32'd1);
    chk("bp_busy_after", {31'd0, busy}, 32'd0);

    // 4: zero length
    do_start(15'h0123, 16'd0);
    chk("len0_c1", {29'd0, out_valid, busy, done}, {29'd0, 3'b010});
    tick();
    chk("len0_c2", {29'd0, out_valid, busy, done}, {29'd0, 3'b001});
    tick();
    chk("len0_c3", {29'd0, out_valid, busy, done}, {29'd0, 3'b000});

    // 5: asynchronous reset at the 3rd word aborts without done
    for (int i = 0; i < 16; i++) mem[15'h0200 + AW'(i)] = 16'h6000 + DW'(i);
    for (int i = 0; i < 3; i++)  mem[15'h0300 + AW'(i)] = 16'h7000 + DW'(i);
    do_start(15'h0200, 16'd16);
    tick();
    tick();
    tick();
    chk("abort_word3", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h6002});
    rst = 1'b1;
    #1;
    chk("abort_imm", {29'd0, out_valid, busy, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_nodone", {29'd0, out_valid, busy, done}, 32'd0);
    do_start(15'h0300, 16'd3);
    expect_stream("after_abort", 3, 16'h7000, -1);

    // 6: start during RUN is ignored
    for (int i = 0; i < 5; i++) mem[15'h0400 + AW'(i)] = 16'h8000 + DW'(i);
    for (int i = 0; i < 2; i++) mem[15'h0500 + AW'(i)] = 16'h9000 + DW'(i);
    do_start(15'h0400, 16'd5);
    expect_stream("ignore_start", 5, 16'h8000, 1);
    tick();
    chk("ignore_idle", {29'd0, out_valid, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sram_stream_reader

`default_nettype wire
